interfaz_adc: RTL and testbench
===============================

INTERFAZ_ADC -- requirements
Module: interfaz_adc

Interface
REQ-001 Parameter N, default 25: width of the sample word Uk, two's complement.
REQ-002 Parameter FRAC, default 16: fractional bits of Uk.
REQ-003 Parameter DIV_MUESTRA, default 985: Clk cycles per sample period (about 44.1 kHz at a 23 ns Clk).
REQ-004 Parameter DIV_SCLK, default 4: Clk cycles per SCLK half-period.
REQ-005 Clk  input  1: single clock; all logic runs on its rising edge.
REQ-006 Reset_n  input  1: reset, asynchronous and active-low.
REQ-007 Habilitar  input  1: enables periodic sampling.
REQ-008 SDATA  input  1: serial data from the 12-bit ADC (4 leading zeros, then 12 bits MSB first).
REQ-009 Bandera_Listo  input  1: done flag from the downstream Filtro.
REQ-010 CS_n  output  1: ADC chip select, active-low.
REQ-011 SCLK  output  1: ADC serial clock, idles high.
REQ-012 Uk  output  N: converted sample; held stable between updates.
REQ-013 Bandera_ADC  output  1: one-cycle pulse marking a new Uk.
REQ-014 Sobrecarga  output  1: sticky flag for a filter overrun.

Function
REQ-015 FSM states: REPOSO, CONVERSION, ENTREGA; reset state is REPOSO.
REQ-016 Sample counter: held at 0 while Habilitar=0; otherwise counts 0..DIV_MUESTRA-1 and wraps, with the tick issued at DIV_MUESTRA-1.
REQ-017 REPOSO -> CONVERSION on tick; CS_n goes low in the next cycle.
REQ-018 In CONVERSION, SCLK toggles every DIV_SCLK cycles, with the first toggle being a fall DIV_SCLK cycles after CS_n falls.
REQ-019 SDATA is sampled into a 16-bit shift register on the Clk cycle in which SCLK goes 0->1; there are exactly 16 rising edges per conversion.
REQ-020 After the 16th rising edge: CONVERSION -> ENTREGA and CS_n goes high.
REQ-021 In ENTREGA, Uk and Bandera_ADC=1 are registered; the state returns to REPOSO next cycle.
REQ-022 Latency: Bandera_ADC is high exactly 32*DIV_SCLK+1 cycles after the CS_n falling edge.
REQ-023 Conversion rule: raw = shift[11:0]; Uk = sign_extend_N(raw - 2048) << (FRAC-11); the 4 leading bits are ignored.
REQ-024 Mapping examples: raw 0x800 -> Uk 0; raw 0xFFF -> 0x000FFE0; raw 0x000 -> 0x1FF0000; no saturation is needed.
REQ-025 Habilitar falling mid-conversion does not abort: the conversion completes and is delivered, then the FSM idles.
REQ-026 A tick arriving outside REPOSO is ignored; the parameters must guarantee this never happens (REQ-030).
REQ-027 Overrun: Sobrecarga is set if Bandera_ADC fires while Bandera_Listo has not been seen high since the previous Bandera_ADC.
REQ-028 Overrun exceptions and clearing: the first Bandera_ADC after reset never sets Sobrecarga; only reset clears it.
REQ-029 Bandera_Listo is detected as a level in any cycle, including the ENTREGA cycle, in which case it counts for the previous sample.
REQ-030 Elaboration-time check: DIV_MUESTRA > 32*DIV_SCLK+2 and FRAC >= 11, else the design does not elaborate.

Reset
REQ-031 Values while Reset_n=0, applied immediately and asynchronously: CS_n=1, SCLK=1, Uk=0, Bandera_ADC=0, Sobrecarga=0, FSM=REPOSO, all counters and the shift register at 0.
REQ-032 A reset mid-conversion discards the partial word; no Bandera_ADC is issued for it.
REQ-033 After Reset_n rises with Habilitar=1, the first CS_n fall is DIV_MUESTRA cycles later.

Structure
REQ-034 Shared parameter package holds N, FRAC, ADC_BITS=12 and OFFSET_ADC=2048, also used by Filtro and its bench.
REQ-035 Sub-module generador_muestreo (sample counter and tick); the FSM, SCLK divider, shift register and scaling stay in interfaz_adc.

Verification
REQ-036 Reset release, Habilitar=1, ADC model returns 0x800 -> CS_n falls at cycle 985, Bandera_ADC at cycle 985+129, Uk=0.
REQ-037 ADC model returns 0xFFF, then 0x000 -> Uk=0x000FFE0, then Uk=0x1FF0000; exactly one 1-cycle pulse each, spaced 985 cycles.
REQ-038 Habilitar dropped 40 cycles into a conversion -> that sample is delivered, then CS_n stays high and no further Bandera_ADC is issued.
REQ-039 Reset_n pulsed low 60 cycles into a conversion -> CS_n=1 and SCLK=1 immediately, no Bandera_ADC, Uk=0.
REQ-040 Bandera_Listo held 0 for two samples -> Sobrecarga=1 at the second Bandera_ADC and stays 1; with Bandera_Listo pulsed after each sample, Sobrecarga stays 0.

Source files
------------

// File: rtl/interfaz_adc_pkg.sv
`default_nettype none
// ============================================================================
// interfaz_adc_pkg -- shared word format and ADC constants (also used by Filtro)
// Revision: 1.0
// ============================================================================
package interfaz_adc_pkg;

  localparam int N          = 25;
  localparam int FRAC       = 16;
  localparam int ADC_BITS   = 12;
  localparam int OFFSET_ADC = 2048;
  localparam int BITS_TRAMA = 16;

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    CONVERSION = 2'd1,
    ENTREGA    = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/interfaz_adc_generador_muestreo.sv
`default_nettype none
// ============================================================================
// generador_muestreo -- free-running sample-period counter with a wrap tick
// Revision: 1.0
// ============================================================================
module generador_muestreo
  import interfaz_adc_pkg::*;
#(
  parameter int DIV_MUESTRA = 985
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilitar,
  output logic tick
);

  localparam int CW = (DIV_MUESTRA > 1) ? $clog2(DIV_MUESTRA) : 1;
  localparam logic [CW-1:0] c_ultimo = CW'(DIV_MUESTRA - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!habilitar || cnt_q == c_ultimo) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the FSM reacts on the same edge the counter wraps.
  assign tick = habilitar && (cnt_q == c_ultimo);

endmodule
`default_nettype wire

// File: rtl/interfaz_adc.sv
`default_nettype none
// ============================================================================
// interfaz_adc -- serial 12-bit ADC reader producing offset-removed Q(N,FRAC) samples
// Revision: 1.0
// ============================================================================
module interfaz_adc
  import interfaz_adc_pkg::*;
#(
  parameter int N           = interfaz_adc_pkg::N,
  parameter int FRAC        = interfaz_adc_pkg::FRAC,
  parameter int DIV_MUESTRA = 985,
  parameter int DIV_SCLK    = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Habilitar,
  input  logic         SDATA,
  input  logic         Bandera_Listo,
  output logic         CS_n,
  output logic         SCLK,
  output logic [N-1:0] Uk,
  output logic         Bandera_ADC,
  output logic         Sobrecarga
);

  localparam int DW     = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam int ESCALA = FRAC - (ADC_BITS - 1);
  localparam logic [DW-1:0] c_div_ultimo = DW'(DIV_SCLK - 1);

  if (DIV_MUESTRA <= 32 * DIV_SCLK + 2 || FRAC < ADC_BITS - 1 || N < FRAC + 1) begin : g_chk_params
    $error("interfaz_adc: sample period too short for a full conversion or word format too narrow");
  end

  // Removing the mid-scale offset of a 12-bit code is a wrap-around subtract.
  function automatic logic [N-1:0] escalar(input logic [ADC_BITS-1:0] raw);
    logic [ADC_BITS-1:0] centrado;
    centrado = raw - ADC_BITS'(OFFSET_ADC);
    return {{(N - ADC_BITS){centrado[ADC_BITS-1]}}, centrado} << ESCALA;
  endfunction

  estado_t               estado_q, estado_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [DW-1:0]         div_q, div_d;
  logic [3:0]            flancos_q, flancos_d;
  logic [BITS_TRAMA-1:0] shift_q, shift_d;
  logic [N-1:0]          uk_q, uk_d;
  logic                  bandera_q, bandera_d;
  logic                  sobrecarga_q, sobrecarga_d;
  logic                  listo_visto_q, listo_visto_d;
  logic                  entregado_q, entregado_d;
  logic                  tick;
  logic                  unused_cabecera;

  generador_muestreo #(
    .DIV_MUESTRA(DIV_MUESTRA)
  ) u_generador (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .habilitar (Habilitar),
    .tick      (tick)
  );

  // The four leading zeros of each frame carry no information.
  assign unused_cabecera = ^shift_q[BITS_TRAMA-1:ADC_BITS];

  always_comb begin
    estado_d      = estado_q;
    cs_n_d        = cs_n_q;
    sclk_d        = sclk_q;
    div_d         = div_q;
    flancos_d     = flancos_q;
    shift_d       = shift_q;
    uk_d          = uk_q;
    bandera_d     = 1'b0;
    sobrecarga_d  = sobrecarga_q;
    listo_visto_d = listo_visto_q | Bandera_Listo;
    entregado_d   = entregado_q;
    case (estado_q)
      REPOSO: begin
        cs_n_d    = 1'b1;
        sclk_d    = 1'b1;
        div_d     = '0;
        flancos_d = '0;
        if (tick) begin
          estado_d = CONVERSION;
          cs_n_d   = 1'b0;
        end
      end
      CONVERSION: begin
        if (div_q == c_div_ultimo) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shift_d   = {shift_q[BITS_TRAMA-2:0], SDATA};
            flancos_d = flancos_q + 4'd1;
            if (flancos_q == 4'd15) begin
              estado_d = ENTREGA;
              cs_n_d   = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ENTREGA: begin
        uk_d      = escalar(shift_q[ADC_BITS-1:0]);
        bandera_d = 1'b1;
        // A Listo seen in this very cycle still acknowledges the previous sample.
        if (entregado_q && !(listo_visto_q || Bandera_Listo)) begin
          sobrecarga_d = 1'b1;
        end
        listo_visto_d = 1'b0;
        entregado_d   = 1'b1;
        estado_d      = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q      <= REPOSO;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      div_q         <= '0;
      flancos_q     <= '0;
      shift_q       <= '0;
      uk_q          <= '0;
      bandera_q     <= 1'b0;
      sobrecarga_q  <= 1'b0;
      listo_visto_q <= 1'b0;
      entregado_q   <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cs_n_q        <= cs_n_d;
      sclk_q        <= sclk_d;
      div_q         <= div_d;
      flancos_q     <= flancos_d;
      shift_q       <= shift_d;
      uk_q          <= uk_d;
      bandera_q     <= bandera_d;
      sobrecarga_q  <= sobrecarga_d;
      listo_visto_q <= listo_visto_d;
      entregado_q   <= entregado_d;
    end
  end

  assign CS_n        = cs_n_q;
  assign SCLK        = sclk_q;
  assign Uk          = uk_q;
  assign Bandera_ADC = bandera_q;
  assign Sobrecarga  = sobrecarga_q;

endmodule
`default_nettype wire

// File: tb/tb_interfaz_adc.sv
`default_nettype none
// ============================================================================
// tb_interfaz_adc -- directed bench with a cycle-level reference model of interfaz_adc
// Revision: 1.0
// ============================================================================
module tb_interfaz_adc;

  localparam int DIV_M = 985;
  localparam int DIV_S = 4;
  localparam int N_W   = 25;
  localparam int LAT   = 32 * DIV_S + 1;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b1;
  logic           Habilitar = 1'b1;
  logic           SDATA = 1'b0;
  logic           Bandera_Listo = 1'b0;
  logic           CS_n, SCLK, Bandera_ADC, Sobrecarga;
  logic [N_W-1:0] Uk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  logic [11:0] adc_q[$];
  logic [11:0] exp_q[$];

  interfaz_adc #(
    .N(N_W), .FRAC(16), .DIV_MUESTRA(DIV_M), .DIV_SCLK(DIV_S)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Habilitar(Habilitar), .SDATA(SDATA),
    .Bandera_Listo(Bandera_Listo), .CS_n(CS_n), .SCLK(SCLK), .Uk(Uk),
    .Bandera_ADC(Bandera_ADC), .Sobrecarga(Sobrecarga)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  function automatic logic [N_W-1:0] scale(input logic [11:0] raw);
    int v;
    v = (int'(raw) - 2048) * (1 << (16 - 11));
    return N_W'(v);
  endfunction

  // ADC: a new bit appears on every SCLK fall, 4 zeros then 12 data bits MSB first.
  initial forever begin
    logic [15:0] word;
    @(negedge CS_n);
    word = {4'h0, (adc_q.size() > 0) ? adc_q.pop_front() : 12'h800};
    for (int i = 15; i >= 0; i--) begin
      @(negedge SCLK or posedge CS_n);
      if (CS_n) break;
      SDATA = word[i];
    end
  end

  // Reference model: timing expressed as a phase count since the conversion start.
  logic           m_busy = 1'b0, m_band = 1'b0, m_sobre = 1'b0, m_seen = 1'b0, m_deliv = 1'b0;
  int             m_run = 0, m_phase = 0;
  logic [11:0]    m_raw = 12'h0;
  logic [N_W-1:0] m_uk = '0;

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      cyc = 0; m_busy = 0; m_band = 0; m_sobre = 0; m_seen = 0; m_deliv = 0;
      m_run = 0; m_phase = 0; m_uk = '0;
    end else begin
      cyc++;
      m_seen = m_seen | Bandera_Listo;
      m_band = 1'b0;
      if (m_busy) begin
        m_phase++;
        if (m_phase == LAT) begin
          m_band = 1'b1;
          m_uk   = scale(m_raw);
          if (m_deliv && !m_seen) m_sobre = 1'b1;
          m_seen  = 1'b0;
          m_deliv = 1'b1;
          m_busy  = 1'b0;
        end
      end
      m_run = Habilitar ? m_run + 1 : 0;
      if (Habilitar && (m_run % DIV_M) == 0 && !m_busy) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_raw   = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h800;
      end
    end
  end

  logic exp_cs, exp_sclk;
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      exp_cs   = !(m_busy && m_phase < 32 * DIV_S);
      exp_sclk = !m_busy || ((m_phase / DIV_S) % 2 == 0);
      check($sformatf("cycle_outputs_c%0d", cyc),
            {3'b000, CS_n, SCLK, Bandera_ADC, Sobrecarga, Uk},
            {3'b000, exp_cs, exp_sclk, m_band, m_sobre, m_uk});
    end
  end

  task automatic step_in;
    @(posedge Clk);
    #2;
  endtask

  task automatic push_raw(input logic [11:0] r);
    adc_q.push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic wait_cs_fall(input string name, output int at);
    logic prev;
    at = -1;
    prev = CS_n;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (prev && !CS_n) begin at = cyc; break; end
      prev = CS_n;
    end
    if (at < 0) timeout_fail(name);
  endtask

  task automatic wait_cs_rise(input string name);
    logic prev;
    bit   found;
    found = 0;
    prev = CS_n;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (!prev && CS_n) begin found = 1; break; end
      prev = CS_n;
    end
    if (!found) timeout_fail(name);
  endtask

  task automatic wait_band(input string name, output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (Bandera_ADC) begin at = cyc; break; end
    end
    if (at < 0) timeout_fail(name);
  endtask

  task automatic pulse_listo;
    step_in; Bandera_Listo = 1'b1;
    step_in; Bandera_Listo = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, tprev, t0, lows, bands;
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    #1 chk_en = 1'b1;
    push_raw(12'h800); push_raw(12'hFFF); push_raw(12'h000); push_raw(12'h123);
    push_raw(12'hABC); push_raw(12'h7FF); push_raw(12'h400);
    step_in; step_in; Reset_n = 1'b1;

    // First sample after reset: mid-scale code
    wait_cs_fall("t1_cs_fall", t);
    check("t1_cs_fall_cycle", t, DIV_M);
    wait_band("t1_band", t);
    check("t1_band_cycle", t, DIV_M + LAT);
    check("t1_uk", Uk, 0);
    check("t1_sobrecarga", Sobrecarga, 0);
    tprev = t;
    pulse_listo;

    // Full-scale positive, then full-scale negative
    wait_band("s2_band", t);
    check("s2_spacing", t - tprev, DIV_M);
    check("s2_uk", Uk, 25'h000FFE0);
    tprev = t;
    @(negedge Clk);
    check("s2_pulse_width", Bandera_ADC, 0);
    pulse_listo;
    wait_band("s3_band", t);
    check("s3_spacing", t - tprev, DIV_M);
    check("s3_uk", Uk, 25'h1FF0000);
    check("s3_sobrecarga", Sobrecarga, 0);
    tprev = t;

    // Listo only in the delivery cycle still acknowledges the previous sample
    wait_cs_rise("s4_cs_rise");
    Bandera_Listo = 1'b1;
    wait_band("s4_band", t);
    Bandera_Listo = 1'b0;
    check("s4_spacing", t - tprev, DIV_M);
    check("s4_uk", Uk, 25'h1FF2460);
    check("s4_sobrecarga", Sobrecarga, 0);

    // No Listo since s4: overrun, and it stays set
    wait_band("s5_band", t);
    check("s5_uk", Uk, 25'h0005780);
    check("s5_sobrecarga", Sobrecarga, 1);
    pulse_listo;
    wait_band("s6_band", t);
    check("s6_uk", Uk, 25'h1FFFFE0);
    check("s6_sobrecarga_sticky", Sobrecarga, 1);
    pulse_listo;

    // Habilitar dropped mid-conversion
    wait_cs_fall("t4_cs_fall", t);
    repeat (40) @(posedge Clk);
    #2 Habilitar = 1'b0;
    wait_band("t4_band", t);
    check("t4_uk", Uk, 25'h1FF8000);
    lows = 0;
    bands = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge Clk);
      if (!CS_n) lows++;
      if (Bandera_ADC) bands++;
    end
    check("t4_idle_cs_low_cycles", lows, 0);
    check("t4_idle_bandera_pulses", bands, 0);

    // Re-enable, then reset 60 cycles into the conversion
    push_raw(12'h555);
    push_raw(12'hC00);
    step_in; Habilitar = 1'b1;
    t0 = cyc;
    wait_cs_fall("t5_cs_fall", t);
    check("t5_reenable_delay", t - t0, DIV_M);
    repeat (60) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("t5_reset_cs_n", CS_n, 1);
    check("t5_reset_sclk", SCLK, 1);
    check("t5_reset_uk", Uk, 0);
    check("t5_reset_bandera", Bandera_ADC, 0);
    check("t5_reset_sobrecarga", Sobrecarga, 0);
    step_in; step_in; Reset_n = 1'b1;
    wait_cs_fall("t5_cs_fall_after_reset", t);
    check("t5_cs_fall_after_reset_cycle", t, DIV_M);
    wait_band("t5_band", t);
    check("t5_band_cycle", t, DIV_M + LAT);
    check("t5_uk", Uk, 25'h0008000);
    check("t5_first_after_reset_sobrecarga", Sobrecarga, 0);

    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
